// File: rtl/icache_pkg.sv
// Shared types and helpers for the N-way instruction cache: FSM states,
// kseg1 decode and the tree pseudo-LRU victim/update functions (up to 4 ways).
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_FLUSHW,
    ST_INVAL
  } state_e;

  localparam logic [2:0] KSEG1_SEG = 3'b101;

  function automatic logic is_kseg1(input logic [31:0] addr);
    return addr[31:29] == KSEG1_SEG;
  endfunction

  // Tree bits: [0] root (0 = left half is victim), [1] ways 0/1, [2] ways 2/3.
  function automatic logic [1:0] plru_victim(input logic [2:0] bits, input int ways);
    logic [1:0] v;
    v = 2'b00;
    if (ways == 4) begin
      v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    end else if (ways == 2) begin
      v = {1'b0, bits[0]};
    end
    return v;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input int ways,
                                            input logic [1:0] way);
    logic [2:0] r;
    r = bits;
    if (ways == 4) begin
      r[0] = ~way[1];
      if (way[1]) r[2] = ~way[0];
      else        r[1] = ~way[0];
    end else if (ways == 2) begin
      r[0] = ~way[0];
    end
    return r;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bits, tag and line storage. Reads are
// asynchronous; writes and per-set valid clears take effect on the clock edge.
module icache_way
  import icache_pkg::*;
#(
  parameter int SET_BITS  = 8,
  parameter int WORD_BITS = 4,
  parameter int TAG_BITS  = 32 - SET_BITS - WORD_BITS - 2,
  localparam int LINE_BITS = 32 << WORD_BITS,
  localparam int SETS      = 1 << SET_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_BITS-1:0]  rd_index,
  output logic                 rd_valid,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [SET_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 clr_en,
  input  logic [SET_BITS-1:0]  clr_index
);

  logic [SETS-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_mem  [SETS];
  logic [LINE_BITS-1:0] data_mem [SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_index] = 1'b0;
    if (wr_en)  valid_d[wr_index]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/data are plain storage; the valid bits alone define what is live after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with pseudo-LRU replacement,
// single-word kseg1 bypass buffer and an invalidate-all sweep.
module icache_nway
  import icache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 8,
  parameter int WORD_BITS = 4,
  localparam int LINE_BITS = 32 << WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_en,
  input  logic [31:0]          cpu_addr,
  input  logic                 cpu_flush,
  input  logic                 cpu_inv_all,
  output logic [31:0]          cpu_inst,
  output logic                 cpu_exc_adel,
  output logic                 cpu_stallreq,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  output logic [3:0]           mem_burst,
  output logic                 mem_uncached,
  input  logic                 mem_addr_ok,
  input  logic                 mem_data_ok,
  input  logic [LINE_BITS-1:0] mem_rdata
);

  localparam int SETS     = 1 << SET_BITS;
  localparam int WORDS    = 1 << WORD_BITS;
  localparam int TAG_BITS = 32 - SET_BITS - WORD_BITS - 2;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W   = (WAYS > 1) ? WAYS - 1 : 1;

  logic [WORD_BITS-1:0] cpu_offset;
  logic [SET_BITS-1:0]  cpu_index;
  logic [TAG_BITS-1:0]  cpu_tag;
  logic                 cpu_unc;

  assign cpu_offset = cpu_addr[WORD_BITS+1:2];
  assign cpu_index  = cpu_addr[SET_BITS+WORD_BITS+1 -: SET_BITS];
  assign cpu_tag    = cpu_addr[31 -: TAG_BITS];
  assign cpu_unc    = is_kseg1(cpu_addr);

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [3:0]           mem_burst_q, mem_burst_d;
  logic                 mem_unc_q, mem_unc_d;
  logic [WAY_W-1:0]     victim_q, victim_d;
  logic                 inv_pend_q, inv_pend_d;
  logic [SET_BITS-1:0]  inv_cnt_q, inv_cnt_d;
  logic                 ubuf_valid_q, ubuf_valid_d;
  logic [31:2]          ubuf_addr_q, ubuf_addr_d;
  logic [31:0]          ubuf_data_q, ubuf_data_d;
  logic [PLRU_W-1:0]    plru_q [SETS];
  logic [PLRU_W-1:0]    plru_d [SETS];

  logic [SET_BITS-1:0]  refill_index;
  logic [TAG_BITS-1:0]  refill_tag;
  logic                 refill_we;
  logic                 clr_en;

  assign refill_index = mem_addr_q[SET_BITS+WORD_BITS+1 -: SET_BITS];
  assign refill_tag   = mem_addr_q[31 -: TAG_BITS];

  logic                 way_valid [WAYS];
  logic [TAG_BITS-1:0]  way_tag   [WAYS];
  logic [LINE_BITS-1:0] way_data  [WAYS];
  logic [WAYS-1:0]      way_hit;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SET_BITS  (SET_BITS),
      .WORD_BITS (WORD_BITS),
      .TAG_BITS  (TAG_BITS)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .rd_index  (cpu_index),
      .rd_valid  (way_valid[w]),
      .rd_tag    (way_tag[w]),
      .rd_data   (way_data[w]),
      .wr_en     (refill_we && (victim_q == WAY_W'(w))),
      .wr_index  (refill_index),
      .wr_tag    (refill_tag),
      .wr_data   (mem_rdata),
      .clr_en    (clr_en),
      .clr_index (inv_cnt_q)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == cpu_tag);
  end

  logic [LINE_BITS-1:0] hit_line;
  logic [WAY_W-1:0]     hit_way;
  logic [31:0]          line_words [WORDS];
  logic                 hit, ubuf_hit, hit_or_ubuf, adel, inst_valid;
  logic [WAY_W-1:0]     victim_sel;

  always_comb begin
    hit_line = '0;
    hit_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_line = way_data[w];
        hit_way  = WAY_W'(w);
      end
    end
  end

  for (genvar i = 0; i < WORDS; i++) begin : g_word
    assign line_words[i] = hit_line[LINE_BITS-1-32*i -: 32];
  end

  assign hit          = (|way_hit) && !cpu_unc;
  assign ubuf_hit     = ubuf_valid_q && (ubuf_addr_q == cpu_addr[31:2]);
  assign hit_or_ubuf  = cpu_unc ? ubuf_hit : hit;
  assign adel         = cpu_en && (cpu_addr[1:0] != 2'b00);
  assign inst_valid   = cpu_en && !adel && (state_q == ST_IDLE) && hit_or_ubuf;

  assign cpu_exc_adel = adel;
  assign cpu_stallreq = (state_q == ST_INVAL) ||
                        (cpu_en && !adel && ((state_q != ST_IDLE) || !hit_or_ubuf));
  assign cpu_inst     = !inst_valid ? 32'h0 :
                        cpu_unc     ? ubuf_data_q : line_words[cpu_offset];

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_burst    = mem_burst_q;
  assign mem_uncached = mem_unc_q;

  // Fill empty ways first so PLRU only arbitrates once the set is full.
  always_comb begin
    victim_sel = WAY_W'(plru_victim(3'(plru_q[cpu_index]), WAYS));
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_sel = WAY_W'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_burst_d  = mem_burst_q;
    mem_unc_d    = mem_unc_q;
    victim_d     = victim_q;
    inv_pend_d   = inv_pend_q || cpu_inv_all;
    inv_cnt_d    = inv_cnt_q;
    ubuf_valid_d = ubuf_valid_q && !cpu_flush;
    ubuf_addr_d  = ubuf_addr_q;
    ubuf_data_d  = ubuf_data_q;
    plru_d       = plru_q;
    refill_we    = 1'b0;
    clr_en       = 1'b0;

    if (WAYS > 1 && inst_valid && !cpu_unc) begin
      plru_d[cpu_index] = PLRU_W'(plru_touch(3'(plru_q[cpu_index]), WAYS, 2'(hit_way)));
    end

    case (state_q)
      ST_IDLE: begin
        if (inv_pend_d) begin
          state_d    = ST_INVAL;
          inv_pend_d = 1'b0;
        end else if (!cpu_flush && cpu_en && !adel && !hit_or_ubuf) begin
          state_d      = ST_REQ;
          mem_req_d    = 1'b1;
          mem_unc_d    = cpu_unc;
          mem_addr_d   = cpu_unc ? {cpu_addr[31:2], 2'b00}
                                 : {cpu_addr[31:WORD_BITS+2], {(WORD_BITS+2){1'b0}}};
          mem_burst_d  = cpu_unc ? 4'h0 : 4'(WORDS - 1);
          victim_d     = victim_sel;
          ubuf_valid_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = cpu_flush ? ST_FLUSHW : ST_WAIT;
        end else if (cpu_flush) begin
          state_d = ST_FLUSHW;
        end
      end
      ST_WAIT: begin
        if (mem_data_ok) begin
          state_d = cpu_flush ? ST_IDLE : ST_DONE;
          if (!cpu_flush && mem_unc_q) begin
            ubuf_valid_d = 1'b1;
            ubuf_addr_d  = mem_addr_q[31:2];
            ubuf_data_d  = mem_rdata[LINE_BITS-1 -: 32];
          end else if (!cpu_flush) begin
            refill_we = 1'b1;
            if (WAYS > 1) begin
              plru_d[refill_index] =
                PLRU_W'(plru_touch(3'(plru_q[refill_index]), WAYS, 2'(victim_q)));
            end
          end
        end else if (cpu_flush) begin
          state_d = ST_FLUSHW;
        end
      end
      // The bridge still owes us this transaction; finish the handshake and drop its data.
      ST_FLUSHW: begin
        if (mem_req_q) begin
          if (mem_addr_ok) mem_req_d = 1'b0;
        end else if (mem_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_INVAL: begin
        clr_en     = 1'b1;
        inv_pend_d = 1'b0;
        inv_cnt_d  = inv_cnt_q + 1'b1;
        if (inv_cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_burst_q  <= '0;
      mem_unc_q    <= 1'b0;
      victim_q     <= '0;
      inv_pend_q   <= 1'b0;
      inv_cnt_q    <= '0;
      ubuf_valid_q <= 1'b0;
      ubuf_addr_q  <= '0;
      ubuf_data_q  <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_burst_q  <= mem_burst_d;
      mem_unc_q    <= mem_unc_d;
      victim_q     <= victim_d;
      inv_pend_q   <= inv_pend_d;
      inv_cnt_q    <= inv_cnt_d;
      ubuf_valid_q <= ubuf_valid_d;
      ubuf_addr_q  <= ubuf_addr_d;
      ubuf_data_q  <= ubuf_data_d;
      plru_q       <= plru_d;
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed self-checking bench for icache_nway (WAYS=2, SET_BITS=8, WORD_BITS=4)
// with a simple one-transaction-at-a-time bridge model.
module tb_icache_nway;

  localparam int LINE_BITS = 512;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cpu_en = 1'b0;
  logic [31:0]          cpu_addr = '0;
  logic                 cpu_flush = 1'b0;
  logic                 cpu_inv_all = 1'b0;
  logic [31:0]          cpu_inst;
  logic                 cpu_exc_adel;
  logic                 cpu_stallreq;
  logic                 mem_req;
  logic [31:0]          mem_addr;
  logic [3:0]           mem_burst;
  logic                 mem_uncached;
  logic                 mem_addr_ok = 1'b0;
  logic                 mem_data_ok = 1'b0;
  logic [LINE_BITS-1:0] mem_rdata = '0;

  int tests_run = 0;
  int tests_failed = 0;

  icache_nway #(.WAYS(2), .SET_BITS(8), .WORD_BITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_addr     (cpu_addr),
    .cpu_flush    (cpu_flush),
    .cpu_inv_all  (cpu_inv_all),
    .cpu_inst     (cpu_inst),
    .cpu_exc_adel (cpu_exc_adel),
    .cpu_stallreq (cpu_stallreq),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_burst    (mem_burst),
    .mem_uncached (mem_uncached),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [LINE_BITS-1:0] make_rdata(input logic [31:0] a, input logic u);
    logic [LINE_BITS-1:0] r;
    r = '0;
    if (u) r[LINE_BITS-1 -: 32] = word_of(a);
    else for (int i = 0; i < 16; i++) r[LINE_BITS-1-32*i -: 32] = word_of({a[31:6], 6'b0} + 32'(4*i));
    return r;
  endfunction

  // Waits (bounded) for a request, acks it, then returns the data two cycles later.
  task automatic bridge(output bit got, output logic [31:0] a, output logic [3:0] b, output logic u);
    got = 1'b0; a = '0; b = '0; u = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        got = 1'b1; a = mem_addr; b = mem_burst; u = mem_uncached;
      end
    end
    if (got) begin
      mem_addr_ok = 1'b1;
      @(negedge clk);
      mem_addr_ok = 1'b0;
      @(negedge clk);
      mem_rdata = make_rdata(a, u);
      mem_data_ok = 1'b1;
      @(negedge clk);
      mem_data_ok = 1'b0;
    end
  endtask

  task automatic fetch_fill(input logic [31:0] addr, output bit got);
    logic [31:0] a; logic [3:0] b; logic u;
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = addr;
    bridge(got, a, b, u);
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
    tests_run++;
    if (cpu_stallreq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b want 0", cpu_stallreq); end
    tests_run++;
    if (cpu_inst !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_inst: got %h want 0", cpu_inst); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = 32'h8000_0042;
    #1;
    tests_run++;
    if (cpu_exc_adel !== 1'b1) begin tests_failed++; $display("[TB] FAIL adel_flag: got %b want 1", cpu_exc_adel); end
    tests_run++;
    if (cpu_stallreq !== 1'b0 || cpu_inst !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL adel_outputs: stall=%b inst=%h want 0/0", cpu_stallreq, cpu_inst);
    end
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL adel_no_req: got %b want 0", mem_req); end
    cpu_en = 1'b0;
  endtask

  task automatic test_cold_miss();
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = 32'h8000_0040;
    #1;
    tests_run++;
    if (cpu_stallreq !== 1'b1 || mem_req !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL cold_detect: stall=%b req=%b want 1/0", cpu_stallreq, mem_req);
    end
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0040 || mem_burst !== 4'hF || mem_uncached !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cold_req: req=%b addr=%h burst=%h unc=%b want 1/80000040/f/0", mem_req, mem_addr, mem_burst, mem_uncached);
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    tests_run++;
    if (mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL cold_req_drop: got %b want 0", mem_req); end
    mem_rdata = make_rdata(32'h8000_0040, 1'b0);
    mem_data_ok = 1'b1;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    tests_run++;
    if (cpu_stallreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL cold_done_stall: got %b want 1", cpu_stallreq); end
    @(negedge clk); #1;
    tests_run++;
    if (cpu_stallreq !== 1'b0 || cpu_inst !== word_of(32'h8000_0040)) begin
      tests_failed++;
      $display("[TB] FAIL cold_result: stall=%b inst=%h want 0/%h", cpu_stallreq, cpu_inst, word_of(32'h8000_0040));
    end
  endtask

  task automatic test_hit_sequence();
    logic [31:0] a;
    for (int i = 1; i < 16; i++) begin
      a = 32'h8000_0040 + 32'(4*i);
      @(negedge clk);
      cpu_en = 1'b1; cpu_addr = a;
      #1;
      tests_run++;
      if (cpu_stallreq !== 1'b0 || mem_req !== 1'b0 || cpu_inst !== word_of(a)) begin
        tests_failed++;
        $display("[TB] FAIL hit_seq[%0d]: stall=%b req=%b inst=%h want 0/0/%h", i, cpu_stallreq, mem_req, cpu_inst, word_of(a));
      end
    end
  endtask

  task automatic test_replacement();
    bit ok_a, ok_b, ok_c;
    fetch_fill(32'h8000_0000, ok_a);
    fetch_fill(32'h8001_0000, ok_b);
    @(negedge clk);
    cpu_addr = 32'h8000_0000;
    #1;
    tests_run++;
    if (!ok_a || !ok_b || cpu_stallreq !== 1'b0 || cpu_inst !== word_of(32'h8000_0000)) begin
      tests_failed++; $display("[TB] FAIL repl_touch_a: ok=%b%b stall=%b inst=%h", ok_a, ok_b, cpu_stallreq, cpu_inst);
    end
    fetch_fill(32'h8002_0000, ok_c);
    tests_run++;
    if (!ok_c || cpu_stallreq !== 1'b0 || cpu_inst !== word_of(32'h8002_0000)) begin
      tests_failed++; $display("[TB] FAIL repl_fill_c: ok=%b stall=%b inst=%h want 1/0/%h", ok_c, cpu_stallreq, cpu_inst, word_of(32'h8002_0000));
    end
    @(negedge clk);
    cpu_addr = 32'h8000_0000;
    #1;
    tests_run++;
    if (cpu_stallreq !== 1'b0 || cpu_inst !== word_of(32'h8000_0000)) begin
      tests_failed++; $display("[TB] FAIL repl_a_kept: stall=%b inst=%h want 0/%h", cpu_stallreq, cpu_inst, word_of(32'h8000_0000));
    end
    @(negedge clk);
    cpu_addr = 32'h8001_0000;
    #1;
    tests_run++;
    if (cpu_stallreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL repl_b_evicted: stall=%b want 1", cpu_stallreq); end
    cpu_en = 1'b0;
  endtask

  task automatic test_uncached();
    bit got, req_seen;
    logic [31:0] a; logic [3:0] b; logic u;
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = 32'hBFC0_0000;
    bridge(got, a, b, u);
    tests_run++;
    if (!got || a !== 32'hBFC0_0000 || b !== 4'h0 || u !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL unc_req: got=%b addr=%h burst=%h unc=%b want 1/bfc00000/0/1", got, a, b, u);
    end
    @(negedge clk); #1;
    tests_run++;
    if (cpu_stallreq !== 1'b0 || cpu_inst !== word_of(32'hBFC0_0000)) begin
      tests_failed++; $display("[TB] FAIL unc_data: stall=%b inst=%h want 0/%h", cpu_stallreq, cpu_inst, word_of(32'hBFC0_0000));
    end
    req_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || cpu_stallreq !== 1'b0) req_seen = 1'b1;
    end
    tests_run++;
    if (req_seen) begin tests_failed++; $display("[TB] FAIL unc_refetch: extra request or stall seen=1 want 0"); end
    cpu_en = 1'b0;
  endtask

  task automatic test_flush();
    bit got;
    logic [31:0] a; logic [3:0] b; logic u;
    @(negedge clk);
    cpu_en = 1'b1; cpu_addr = 32'h8000_0100;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL flush_req: req never seen want 1"); end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    cpu_flush = 1'b1;
    @(negedge clk);
    cpu_flush = 1'b0;
    #1;
    tests_run++;
    if (cpu_stallreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_wait_stall: got %b want 1", cpu_stallreq); end
    mem_rdata = make_rdata(32'h8000_0100, 1'b0);
    mem_data_ok = 1'b1;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    tests_run++;
    if (cpu_stallreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_discard: stall=%b want 1 (line must miss)", cpu_stallreq); end
    bridge(got, a, b, u);
    tests_run++;
    if (!got || a !== 32'h8000_0100) begin tests_failed++; $display("[TB] FAIL flush_refetch_req: got=%b addr=%h want 1/80000100", got, a); end
    @(negedge clk); #1;
    tests_run++;
    if (cpu_stallreq !== 1'b0 || cpu_inst !== word_of(32'h8000_0100)) begin
      tests_failed++; $display("[TB] FAIL flush_refill: stall=%b inst=%h want 0/%h", cpu_stallreq, cpu_inst, word_of(32'h8000_0100));
    end
    cpu_en = 1'b0;
  endtask

  task automatic test_inv_all();
    int n;
    logic [31:0] addrs [4];
    addrs[0] = 32'h8000_0040; addrs[1] = 32'h8000_0000;
    addrs[2] = 32'h8002_0000; addrs[3] = 32'h8000_0100;
    @(negedge clk);
    cpu_en = 1'b0; cpu_inv_all = 1'b1;
    @(negedge clk);
    cpu_inv_all = 1'b0;
    n = 0;
    while (cpu_stallreq === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (n != 256) begin tests_failed++; $display("[TB] FAIL inv_duration: stalled %0d cycles want 256", n); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_en = 1'b1; cpu_addr = addrs[i];
      #1;
      tests_run++;
      if (cpu_stallreq !== 1'b1) begin tests_failed++; $display("[TB] FAIL inv_miss[%0d]: addr=%h stall=%b want 1", i, addrs[i], cpu_stallreq); end
      cpu_en = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_misaligned();
    test_cold_miss();
    test_hit_sequence();
    test_replacement();
    test_uncached();
    test_flush();
    test_inv_all();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
